// File: rtl/cut_seq_pkg.sv
// Shared types, LFSR tap table and arithmetic helpers for the cut activity sequencer.
// Counter arithmetic is carried in 32 bits, so CNT_W must not exceed 32.
package cut_seq_pkg;

    localparam int unsigned ARITH_W = 32;
    localparam int unsigned TAP_W   = 8;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_LFSR = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Maximal-length Fibonacci tap masks, indexed by register width.
    function automatic logic [TAP_W-1:0] lfsr_taps(input int unsigned n);
        case (n)
            2:       return 8'b0000_0011;
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            8:       return 8'b1011_1000;
            default: return 8'b0000_0011;
        endcase
    endfunction

    // Encoding 3 is reserved and behaves as binary.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_GRAY;
            2'd2:    return MODE_LFSR;
            default: return MODE_BIN;
        endcase
    endfunction

    function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                   input logic [ARITH_W-1:0] b,
                                                   input logic [ARITH_W-1:0] maxv);
        logic [ARITH_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[ARITH_W-1:0];
    endfunction

    // True when the addition had to be clipped at maxv.
    function automatic logic add_ovf(input logic [ARITH_W-1:0] a,
                                     input logic [ARITH_W-1:0] b,
                                     input logic [ARITH_W-1:0] maxv);
        logic [ARITH_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv});
    endfunction

endpackage

// File: rtl/cut_seq_if.sv
// Controller-side bundle: run request, configuration and the result handshake.
interface cut_seq_if #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic [1:0]        mode;
    logic [NUM_IN-1:0] seed;
    logic [NUM_IN:0]   vec_count;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  ones_cnt;
    logic [CNT_W-1:0]  out_tgl_cnt;
    logic [CNT_W-1:0]  in_tgl_cnt;
    logic              sat;

    modport master (
        output start, mode, seed, vec_count, res_ready,
        input  busy, res_valid, ones_cnt, out_tgl_cnt, in_tgl_cnt, sat
    );

    modport slave (
        input  start, mode, seed, vec_count, res_ready,
        output busy, res_valid, ones_cnt, out_tgl_cnt, in_tgl_cnt, sat
    );
endinterface

// File: rtl/cut_vec_gen.sv
// Next-vector generator: first vector on load, binary/Gray/LFSR successor on advance.
module cut_vec_gen
    import cut_seq_pkg::*;
#(
    parameter int unsigned NUM_IN = 4
) (
    input  mode_t             mode,
    input  logic              load,
    input  logic              advance,
    input  logic [NUM_IN-1:0] seed,
    input  logic [NUM_IN-1:0] idx,
    input  logic [NUM_IN-1:0] vec,
    output logic [NUM_IN-1:0] vec_nxt_c
);

    localparam logic [NUM_IN-1:0] TAPS = NUM_IN'(lfsr_taps(NUM_IN));

    logic [NUM_IN-1:0] seed_eff_c;

    // An all-zero seed would lock the LFSR, so it starts from all-ones instead.
    always_comb begin
        seed_eff_c = (seed == '0) ? '1 : seed;
        vec_nxt_c  = vec;
        if (load) begin
            vec_nxt_c = (mode == MODE_LFSR) ? seed_eff_c : '0;
        end else if (advance) begin
            case (mode)
                MODE_GRAY: vec_nxt_c = idx ^ (idx >> 1);
                MODE_LFSR: vec_nxt_c = {vec[NUM_IN-2:0], ^(vec & TAPS)};
                default:   vec_nxt_c = idx;
            endcase
        end
    end

endmodule

// File: rtl/cut_activity_sequencer.sv
// Drives a stimulus stream into one cut, accumulates output/input activity and
// returns the counts through a valid/ready result handshake.
module cut_activity_sequencer
    import cut_seq_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    cut_seq_if.slave          bus,
    output logic [NUM_IN-1:0] vec_out,
    input  logic              cut_out
);

    localparam int unsigned        IDX_W     = NUM_IN + 1;
    localparam logic [IDX_W-1:0]   FULL_BIN  = {1'b1, {NUM_IN{1'b0}}};
    localparam logic [IDX_W-1:0]   FULL_LFSR = {1'b0, {NUM_IN{1'b1}}};
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [ARITH_W-1:0] CNT_MAX32 = ARITH_W'(CNT_MAX);

    state_t            state_q, state_nxt;
    mode_t             mode_q, mode_in_c, gen_mode_c;
    logic [IDX_W-1:0]  n_q, idx_q, idx_nxt_c, full_c, n_eff_c;
    logic [NUM_IN-1:0] prev_vec_q, vec_nxt_c;
    logic              prev_cut_q, first_q;
    logic              load_c, adv_c, last_c, ovf_c;
    logic [ARITH_W-1:0] ones_add_c, otgl_add_c, itgl_add_c;
    logic [CNT_W-1:0]  ones_nxt_c, otgl_nxt_c, itgl_nxt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // Next state, run control and effective vector count.
    always_comb begin
        state_nxt  = state_q;
        load_c     = 1'b0;
        adv_c      = 1'b0;
        mode_in_c  = decode_mode(bus.mode);
        gen_mode_c = (state_q == ST_IDLE) ? mode_in_c : mode_q;
        idx_nxt_c  = idx_q + IDX_W'(1);
        last_c     = (idx_nxt_c == n_q);
        full_c     = (mode_in_c == MODE_LFSR) ? FULL_LFSR : FULL_BIN;
        n_eff_c    = ((bus.vec_count == '0) || (bus.vec_count > FULL_BIN)) ? full_c : bus.vec_count;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    load_c    = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_c) state_nxt = ST_DONE;
                else        adv_c     = 1'b1;
            end
            ST_DONE: begin
                if (bus.res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Saturating counter updates for the current sample.
    always_comb begin
        ones_add_c = ARITH_W'(cut_out);
        otgl_add_c = '0;
        itgl_add_c = '0;
        if (!first_q) begin
            otgl_add_c = ARITH_W'(cut_out ^ prev_cut_q);
            itgl_add_c = ARITH_W'($countones(vec_out ^ prev_vec_q));
        end
        ones_nxt_c = CNT_W'(sat_add(ARITH_W'(bus.ones_cnt), ones_add_c, CNT_MAX32));
        otgl_nxt_c = CNT_W'(sat_add(ARITH_W'(bus.out_tgl_cnt), otgl_add_c, CNT_MAX32));
        itgl_nxt_c = CNT_W'(sat_add(ARITH_W'(bus.in_tgl_cnt), itgl_add_c, CNT_MAX32));
        ovf_c      = add_ovf(ARITH_W'(bus.ones_cnt), ones_add_c, CNT_MAX32)
                   | add_ovf(ARITH_W'(bus.out_tgl_cnt), otgl_add_c, CNT_MAX32)
                   | add_ovf(ARITH_W'(bus.in_tgl_cnt), itgl_add_c, CNT_MAX32);
    end

    cut_vec_gen #(.NUM_IN(NUM_IN)) u_gen (
        .mode      (gen_mode_c),
        .load      (load_c),
        .advance   (adv_c),
        .seed      (bus.seed),
        .idx       (idx_nxt_c[NUM_IN-1:0]),
        .vec       (vec_out),
        .vec_nxt_c (vec_nxt_c)
    );

    // Datapath: the final vector is not advanced, so vec_out holds it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out         <= '0;
            mode_q          <= MODE_BIN;
            n_q             <= '0;
            idx_q           <= '0;
            prev_vec_q      <= '0;
            prev_cut_q      <= 1'b0;
            first_q         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.ones_cnt    <= '0;
            bus.out_tgl_cnt <= '0;
            bus.in_tgl_cnt  <= '0;
            bus.sat         <= 1'b0;
        end else begin
            bus.busy      <= (state_nxt == ST_RUN);
            bus.res_valid <= (state_nxt == ST_DONE);
            vec_out       <= vec_nxt_c;
            if (load_c) begin
                mode_q          <= mode_in_c;
                n_q             <= n_eff_c;
                idx_q           <= '0;
                first_q         <= 1'b1;
                bus.ones_cnt    <= '0;
                bus.out_tgl_cnt <= '0;
                bus.in_tgl_cnt  <= '0;
                bus.sat         <= 1'b0;
            end else if (state_q == ST_RUN) begin
                idx_q           <= idx_nxt_c;
                first_q         <= 1'b0;
                prev_vec_q      <= vec_out;
                prev_cut_q      <= cut_out;
                bus.ones_cnt    <= ones_nxt_c;
                bus.out_tgl_cnt <= otgl_nxt_c;
                bus.in_tgl_cnt  <= itgl_nxt_c;
                bus.sat         <= bus.sat | ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_cut_activity_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed results, negedge monitors pop them on each handshake.
module tb_cut_activity_sequencer;
    import cut_seq_pkg::*;

    localparam int unsigned NI = 4;

    typedef struct {
        int unsigned ones;
        int unsigned otgl;
        int unsigned itgl;
        int unsigned sat;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cut_seq_if #(.NUM_IN(NI), .CNT_W(16)) if_a ();
    cut_seq_if #(.NUM_IN(NI), .CNT_W(3))  if_b ();

    logic [NI-1:0] vec_a, vec_b;
    logic          cut_a, cut_b;
    assign cut_a = vec_a[0];
    assign cut_b = 1'b1;

    cut_activity_sequencer #(.NUM_IN(NI), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .vec_out(vec_a), .cut_out(cut_a)
    );
    cut_activity_sequencer #(.NUM_IN(NI), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .vec_out(vec_b), .cut_out(cut_b)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          exp_a[$];
    exp_t          exp_b[$];
    logic [NI-1:0] vec_log[$];
    int unsigned   run_a = 0;
    int unsigned   run_b = 0;

    function automatic void check(input string name, input longint unsigned act, input longint unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) run_a = 0;
        else begin
            if (if_a.busy) begin
                run_a++;
                vec_log.push_back(vec_a);
            end
            if (if_a.res_valid && if_a.res_ready) begin
                if (exp_a.size() == 0) check("a_unexpected_result", 1, 0);
                else begin
                    e = exp_a.pop_front();
                    check("a_ones", if_a.ones_cnt, e.ones);
                    check("a_out_tgl", if_a.out_tgl_cnt, e.otgl);
                    check("a_in_tgl", if_a.in_tgl_cnt, e.itgl);
                    check("a_sat", if_a.sat, e.sat);
                    check("a_run_cycles", run_a, e.cyc);
                end
                run_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) run_b = 0;
        else begin
            if (if_b.busy) run_b++;
            if (if_b.res_valid && if_b.res_ready) begin
                if (exp_b.size() == 0) check("b_unexpected_result", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    check("b_ones", if_b.ones_cnt, e.ones);
                    check("b_out_tgl", if_b.out_tgl_cnt, e.otgl);
                    check("b_in_tgl", if_b.in_tgl_cnt, e.itgl);
                    check("b_sat", if_b.sat, e.sat);
                    check("b_run_cycles", run_b, e.cyc);
                end
                run_b = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit b, input logic [1:0] m, input logic [NI-1:0] sd, input logic [NI:0] vc);
        if (b) begin
            if_b.mode = m; if_b.seed = sd; if_b.vec_count = vc; if_b.start = 1'b1;
        end else begin
            if_a.mode = m; if_a.seed = sd; if_a.vec_count = vc; if_a.start = 1'b1;
            vec_log.delete();
        end
        tick();
        if_a.start = 1'b0;
        if_b.start = 1'b0;
    endtask

    task automatic wait_valid(input bit b, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b ? if_b.res_valid : if_a.res_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, ok, 1);
    endtask

    task automatic accept(input bit b);
        if (b) if_b.res_ready = 1'b1; else if_a.res_ready = 1'b1;
        tick();
        if_a.res_ready = 1'b0;
        if_b.res_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] seen;
        int          distinct;
        logic [NI-1:0] v;

        if_a.start = 0; if_a.mode = 0; if_a.seed = 0; if_a.vec_count = 0; if_a.res_ready = 0;
        if_b.start = 0; if_b.mode = 0; if_b.seed = 0; if_b.vec_count = 0; if_b.res_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec_a", vec_a, 0);
        check("rst_busy_a", if_a.busy, 0);
        check("rst_valid_a", if_a.res_valid, 0);
        check("rst_ones_a", if_a.ones_cnt, 0);
        check("rst_sat_a", if_a.sat, 0);
        check("rst_ones_b", if_b.ones_cnt, 0);
        rst = 1'b0;
        tick();
        check("idle_busy_a", if_a.busy, 0);

        // Binary, full count
        exp_a.push_back('{8, 15, 26, 0, 16});
        start_run(0, 2'd0, 4'h0, 5'd0);
        check("bin_busy_first", if_a.busy, 1);
        wait_valid(0, "bin_done");
        accept(0);
        check("bin_idle_valid", if_a.res_valid, 0);
        check("bin_idle_ones_kept", if_a.ones_cnt, 8);

        // Gray, full count
        exp_a.push_back('{8, 8, 15, 0, 16});
        start_run(0, 2'd1, 4'h0, 5'd0);
        wait_valid(0, "gray_done");
        check("gray_len", vec_log.size(), 16);
        check("gray_v0", vec_log[0], 0);
        check("gray_v1", vec_log[1], 1);
        check("gray_v2", vec_log[2], 3);
        check("gray_v3", vec_log[3], 2);
        check("gray_v4", vec_log[4], 6);
        accept(0);

        // LFSR, zero seed, full count
        exp_a.push_back('{8, 8, 31, 0, 15});
        start_run(0, 2'd2, 4'h0, 5'd0);
        check("lfsr_first_vec", vec_a, 4'hF);
        wait_valid(0, "lfsr_done");
        seen = '0;
        distinct = 0;
        foreach (vec_log[i]) begin
            v = vec_log[i];
            if (v != 0 && !seen[v]) begin
                seen[v] = 1'b1;
                distinct++;
            end
        end
        check("lfsr_distinct", distinct, 15);
        accept(0);

        // LFSR, 16 vectors: sequence wraps back to the seed
        exp_a.push_back('{9, 8, 32, 0, 16});
        start_run(0, 2'd2, 4'h0, 5'd16);
        wait_valid(0, "lfsr16_done");
        check("lfsr16_vec16", vec_log[15], 4'hF);
        accept(0);

        // LFSR, explicit seed 9, 3 vectors: 9,3,6
        exp_a.push_back('{2, 1, 4, 0, 3});
        start_run(0, 2'd2, 4'h9, 5'd3);
        wait_valid(0, "lfsr_seed_done");
        check("lfsr_seed_v0", vec_log[0], 4'h9);
        check("lfsr_seed_hold", vec_a, 4'h6);
        accept(0);

        // Oversized vec_count clamps to the full count
        exp_a.push_back('{8, 15, 26, 0, 16});
        start_run(0, 2'd0, 4'h0, 5'd31);
        wait_valid(0, "clamp_done");
        accept(0);

        // vec_count=5 with start pulses in RUN, in DONE and on the accept cycle
        exp_a.push_back('{2, 4, 7, 0, 5});
        start_run(0, 2'd0, 4'h0, 5'd5);
        tick();
        if_a.start = 1'b1; if_a.mode = 2'd1;
        tick();
        if_a.start = 1'b0; if_a.mode = 2'd0;
        wait_valid(0, "cnt5_done");
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        check("cnt5_done_start_valid", if_a.res_valid, 1);
        check("cnt5_done_start_busy", if_a.busy, 0);
        if_a.start = 1'b1;
        accept(0);
        if_a.start = 1'b0;
        check("cnt5_accept_valid", if_a.res_valid, 0);
        tick();
        check("cnt5_accept_start_busy", if_a.busy, 0);
        check("cnt5_idle_ones_kept", if_a.ones_cnt, 2);

        // CNT_W=3 saturation and held handshake
        exp_b.push_back('{7, 0, 7, 1, 16});
        start_run(1, 2'd0, 4'h0, 5'd0);
        wait_valid(1, "sat_done");
        for (int i = 0; i < 5; i++) begin
            check("sat_hold_valid", if_b.res_valid, 1);
            check("sat_hold_ones", if_b.ones_cnt, 7);
            check("sat_hold_sat", if_b.sat, 1);
            tick();
        end
        accept(1);
        check("sat_release_valid", if_b.res_valid, 0);
        check("sat_release_busy", if_b.busy, 0);

        // Reset mid-RUN aborts, then a fresh run completes correctly
        start_run(0, 2'd0, 4'h0, 5'd0);
        repeat (6) tick();
        check("abort_pre_busy", if_a.busy, 1);
        check("abort_pre_vec", vec_a, 6);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", if_a.busy, 0);
        check("abort_vec", vec_a, 0);
        check("abort_ones", if_a.ones_cnt, 0);
        check("abort_in_tgl", if_a.in_tgl_cnt, 0);
        check("abort_valid", if_a.res_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        exp_a.push_back('{8, 15, 26, 0, 16});
        start_run(0, 2'd0, 4'h0, 5'd0);
        wait_valid(0, "post_abort_done");
        accept(0);

        repeat (3) tick();
        check("scoreboard_a_empty", exp_a.size(), 0);
        check("scoreboard_b_empty", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cut_activity_sequencer.md
Name: cut_activity_sequencer

Overview:
Sequencer that exercises one combinational sub-circuit under test (a cut of up to 8 inputs) for power and rewrite experiments. It drives a registered input vector stream in binary, Gray or LFSR order and samples the cut's single output every cycle. It accumulates output ones, output toggles and input bit toggles, then returns the results through a valid/ready handshake. It sits between the experiment controller and each sub-circuit instance.

Parameters:
NUM_IN, 4, cut input count; legal 2..8
CNT_W, 16, width of each result counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle run request; accepted only in IDLE
mode  in  2  0 binary, 1 Gray, 2 LFSR, 3 reserved (treated as binary)
seed  in  NUM_IN  LFSR start state; 0 is replaced by all-ones
vec_count  in  NUM_IN+1  vectors to apply; 0 selects the full count
vec_out  out  NUM_IN  registered stimulus to the cut
cut_out  in  1  combinational cut output for the current vec_out
busy  out  1  high in RUN
res_valid  out  1  results available (DONE)
res_ready  in  1  consumer accepts results
ones_cnt  out  CNT_W  cycles with cut_out=1
out_tgl_cnt  out  CNT_W  cut_out changes between consecutive samples
in_tgl_cnt  out  CNT_W  sum of popcount(vec[i] ^ vec[i-1])
sat  out  1  any counter saturated

Behaviour:
- Reset: state IDLE; vec_out, all counters, busy, res_valid and sat are 0. Reset is asserted asynchronously; deassertion is synchronised by the top level.
- FSM states are IDLE, RUN and DONE.
- IDLE to RUN on start:
  - Latch mode and the effective count N.
  - N = vec_count, or when vec_count=0: 2^NUM_IN for binary/Gray, 2^NUM_IN-1 for LFSR.
  - Load vec_out with the first vector: 0 for binary/Gray, or seed (zero replaced by all-ones) for LFSR.
  - Clear the counters and sat.
- RUN, every cycle:
  - Sample cut_out against the current vec_out.
  - Increment ones_cnt if cut_out=1.
  - Except on the first sample: increment out_tgl_cnt if cut_out differs from the previous sample, and add popcount(vec_out ^ prev_vec) to in_tgl_cnt.
  - Advance the index.
  - Then advance vec_out:
    - binary: idx;
    - Gray: idx ^ (idx>>1);
    - LFSR: Fibonacci shift left, feedback = XOR of the tap bits from the package table.
- RUN to DONE after the N-th sample; one vector per cycle, so RUN lasts exactly N cycles.
- vec_out holds its last value in DONE and IDLE.
- Counters saturate at 2^CNT_W-1 with no wrap; sat is sticky until the next start.
- DONE: res_valid=1 and the counters are stable. DONE to IDLE on res_valid & res_ready; the counters keep their values in IDLE.
- start in RUN or DONE is ignored. start in the same cycle as the DONE-to-IDLE transition is ignored.
- rst mid-RUN aborts the run: all outputs return to reset values immediately and no partial result is flagged.
- Arithmetic:
  - Index width is NUM_IN+1.
  - The in_tgl_cnt increment is at most NUM_IN and is added with saturation.
  - vec_count > 2^NUM_IN is clamped to the full count.

Decomposition:
- Package cut_seq_pkg holds:
  - mode enum (MODE_BIN, MODE_GRAY, MODE_LFSR);
  - state enum;
  - the LFSR tap-mask table indexed by NUM_IN (2:11, 3:110, 4:1100, 5:10100, 6:110000, 7:1100000, 8:10111000);
  - a saturating-add function.
- One sub-module, cut_vec_gen: mode, load, advance, seed -> next vector.
- Counters and the FSM stay in the top module.

Test Plan:
- Binary, NUM_IN=4, vec_count=0, bench ties cut_out=vec_out[0] -> RUN 16 cycles; ones=8, out_tgl=15, in_tgl=26, sat=0.
- Gray, same tie-off -> vec_out sequence 0,1,3,2,6,...; ones=8, out_tgl=8, in_tgl=15.
- LFSR, seed=0, vec_count=0 -> first vec_out=4'hF; 15 distinct nonzero vectors with no repeat; ones=8; the 16th vector equals 4'hF.
- CNT_W=3, binary, cut_out tied 1 -> ones_cnt=7, sat=1, out_tgl=0. Hold res_ready=0 for 5 cycles -> res_valid and the counters stay stable; release -> IDLE next cycle.
- start pulsed in RUN and in DONE -> ignored, counts unchanged. vec_count=5 -> exactly 5 RUN cycles.
- rst asserted on RUN cycle 7 -> busy=0, vec_out=0, counters=0 on the same edge. A new start afterwards gives full, correct results.
